gpr_dump: RTL and testbench

- Sequential reader on the far side of the GPR register file: walks a register range through one GPR read port and streams each (index, value) pair out over a valid/ready handshake.
- Used for debug register dumps and end-of-simulation state checks.
- Sits beside the datapath and shares read port 2 through an external mux selected by `busy`.
- Never writes the GPR.

---
 rtl/cpu_defs.sv | 14 +
 rtl/gpr_dump.sv | 116 +++++++++++
 tb/tb_gpr_dump.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU constants: GPR geometry and the register-dump FSM state encoding.
package cpu_defs;

  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_READ = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/gpr_dump.sv
// Walks GPR[FIRST..LAST] through one read port and streams (index, value) pairs
// over a valid/ready handshake. Read-only with respect to the register file.
module gpr_dump
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W = cpu_defs::DATA_W,
  parameter int unsigned ADDR_W = GPR_ADDR_W,
  parameter int unsigned FIRST  = 0,
  parameter int unsigned LAST   = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  if (FIRST > LAST) begin : g_bad_range
    $error("gpr_dump: FIRST must not exceed LAST");
  end
  if (LAST >= (1 << ADDR_W)) begin : g_bad_last
    $error("gpr_dump: LAST does not fit in ADDR_W bits");
  end

  localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(LAST);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic [DATA_W-1:0] odata_q, odata_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    unique case (state_q)
      DUMP_IDLE: begin
        idx_d = FirstIdx;
        if (start) state_d = DUMP_READ;
      end
      DUMP_READ: begin
        if (abort) begin
          state_d = DUMP_IDLE;
          idx_d   = FirstIdx;
          valid_d = 1'b0;
        end else begin
          odata_d = rd_data;
          oaddr_d = idx_q;
          valid_d = 1'b1;
          state_d = DUMP_SEND;
        end
      end
      DUMP_SEND: begin
        // Abort beats a simultaneous handshake: the word is treated as undelivered.
        if (abort) begin
          state_d = DUMP_IDLE;
          idx_d   = FirstIdx;
          valid_d = 1'b0;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = DUMP_FIN;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = DUMP_READ;
          end
        end
      end
      DUMP_FIN: begin
        // Park the index on FIRST so rd_addr shows FIRST while idle.
        idx_d   = FirstIdx;
        state_d = DUMP_IDLE;
      end
      default: begin
        idx_d   = FirstIdx;
        valid_d = 1'b0;
        state_d = DUMP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= FirstIdx;
      valid_q <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
    end
  end

  assign rd_addr   = idx_q;
  assign out_valid = valid_q;
  assign out_addr  = oaddr_q;
  assign out_data  = odata_q;
  assign busy      = (state_q != DUMP_IDLE);
  assign done      = (state_q == DUMP_FIN);

endmodule

// File: tb/tb_gpr_dump.sv
// Scoreboard bench for gpr_dump: a full 0..31 instance and a single-register (30..30) instance.
module tb_gpr_dump;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [4:0]  rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic        out_valid, busy, done;

  logic        start1, abort1, out_ready1;
  logic [4:0]  rd_addr1, out_addr1;
  logic [31:0] rd_data1, out_data1;
  logic        out_valid1, busy1, done1;

  logic [31:0] gpr [32];
  exp_t        q[$];
  exp_t        q1[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  int          done_cnt1 = 0;
  int          pops = 0;
  int          n;

  always #5 clk = ~clk;

  assign rd_data  = gpr[rd_addr];
  assign rd_data1 = gpr[rd_addr1];

  gpr_dump #(.DATA_W(32), .ADDR_W(5), .FIRST(0), .LAST(31)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
  );

  gpr_dump #(.DATA_W(32), .ADDR_W(5), .FIRST(30), .LAST(30)) u_dut_one (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_addr(out_addr1), .out_data(out_data1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Handshakes are judged mid-cycle, when inputs and outputs are both settled.
  always @(negedge clk) begin : mon_full
    exp_t e;
    if (reset) begin
      if (done) done_cnt++;
      if (out_valid && out_ready && !abort) begin
        if (q.size() == 0) check("sb_underflow", 1, 0);
        else begin
          e = q.pop_front();
          check("word_addr", out_addr, e.a);
          check("word_data", out_data, e.d);
          pops++;
        end
      end
    end
  end

  always @(negedge clk) begin : mon_one
    exp_t e;
    if (reset) begin
      if (done1) done_cnt1++;
      if (out_valid1 && out_ready1 && !abort1) begin
        if (q1.size() == 0) check("sb1_underflow", 1, 0);
        else begin
          e = q1.pop_front();
          check("one_addr", out_addr1, e.a);
          check("one_data", out_data1, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all();
    for (int i = 0; i < 32; i++) q.push_back({5'(i), gpr[i]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 300) begin
      tick();
      cycles++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic wait_word(input logic [4:0] a);
    int c = 0;
    while (!(out_valid && out_addr == a) && c < 300) begin
      tick();
      c++;
    end
    check("reach_word", (out_valid && out_addr == a), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b1;
    for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
    gpr[2]  = 32'h1234_5678;
    gpr[3]  = 32'h8765_4321;
    gpr[30] = 32'hDEAD_BEEF;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_addr_one", rd_addr1, 30);
    reset = 1'b1;
    tick();

    // Full dump, consumer always ready.
    push_all();
    pulse_start();
    wait_done(n);
    check("done_latency", n, 64);
    tick();
    check("full_busy_after", busy, 0);
    check("full_done_after", done, 0);
    check("idle_rd_addr", rd_addr, 0);
    check("full_pops", pops, 32);
    check("full_q_empty", q.size(), 0);
    check("full_done_cnt", done_cnt, 1);

    // Backpressure while word 2 is presented.
    push_all();
    pulse_start();
    wait_word(5'd2);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'h1234_5678);
      check("bp_addr", out_addr, 2);
    end
    out_ready = 1'b1;
    tick();
    check("bp_valid_drop", out_valid, 0);
    tick();
    check("bp_word3_valid", out_valid, 1);
    check("bp_word3_addr", out_addr, 3);
    wait_done(n);
    tick();
    check("bp_done_cnt", done_cnt, 2);

    // Abort with a concurrent handshake while word 5 is valid.
    push_all();
    pulse_start();
    wait_word(5'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    q.delete();
    tick();
    check("abort_no_done", done_cnt, 2);
    push_all();
    pulse_start();
    check("restart_rd_addr", rd_addr, 0);
    wait_done(n);
    tick();
    check("restart_done_cnt", done_cnt, 3);
    check("restart_q_empty", q.size(), 0);

    // Reset during READ with start held high.
    push_all();
    pulse_start();
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    start = 1'b1;
    tick();
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_rd_addr", rd_addr, 0);
    check("mrst_out_addr", out_addr, 0);
    check("mrst_out_data", out_data, 0);
    reset = 1'b1;
    start = 1'b0;
    tick();
    check("mrst_still_idle", busy, 0);
    q.delete();

    // start pulses during SEND are ignored.
    push_all();
    pulse_start();
    n = 0;
    while (!done && n < 300) begin
      start = out_valid;
      tick();
      n++;
    end
    start = 1'b0;
    check("sp_done_seen", done, 1);
    check("sp_latency", n, 64);
    repeat (3) tick();
    check("sp_done_cnt", done_cnt, 4);
    check("sp_busy", busy, 0);
    check("sp_q_empty", q.size(), 0);

    // Single-register build; GPR write in the SEND cycle must not leak in.
    q1.push_back({5'd30, 32'hDEAD_BEEF});
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("one_read_addr", rd_addr1, 30);
    check("one_read_busy", busy1, 1);
    tick();
    gpr[30] = 32'h0BAD_F00D;
    check("one_send_valid", out_valid1, 1);
    check("one_send_data", out_data1, 32'hDEAD_BEEF);
    tick();
    check("one_done", done1, 1);
    tick();
    check("one_done_off", done1, 0);
    check("one_busy_off", busy1, 0);
    check("one_done_cnt", done_cnt1, 1);
    check("one_q_empty", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
